// File: rtl/multimode_led_counter.sv
// Prescaled LED counter: up-wrap, down-wrap, bounce and up-saturate modes
// with registered tick/terminal-count strobes and polarity-selectable LEDs.
module multimode_led_counter #(
    parameter int CNT_W          = 8,
    parameter int PRESC_W        = 24,
    parameter int LED_N          = 4,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               load,
    input  logic [CNT_W-1:0]   load_val,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc_div,
    output logic [CNT_W-1:0]   count,
    output logic               dir,
    output logic               tick,
    output logic               tc,
    output logic [LED_N-1:0]   leds
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               tc_q, tc_d;

    logic               step;
    logic               at_max, at_zero;
    logic [CNT_W-1:0]   cnt_inc, cnt_dec;

    // >= rather than == so lowering presc_div mid-count cannot skip a step
    assign step    = en && (presc_cnt_q >= presc_div);
    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);
    assign cnt_inc = count_q + CNT_W'(1);
    assign cnt_dec = count_q - CNT_W'(1);

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        count_d     = count_q;
        dir_d       = dir_q;
        tick_d      = 1'b0;
        tc_d        = 1'b0;
        if (clr) begin
            presc_cnt_d = '0;
            count_d     = '0;
            dir_d       = 1'b0;
        end else if (load) begin
            presc_cnt_d = '0;
            count_d     = load_val;
        end else if (step) begin
            presc_cnt_d = '0;
            tick_d      = 1'b1;
            unique case (mode)
                2'b00: begin
                    count_d = cnt_inc;
                    dir_d   = 1'b0;
                    tc_d    = at_max;
                end
                2'b01: begin
                    count_d = cnt_dec;
                    dir_d   = 1'b1;
                    tc_d    = at_zero;
                end
                2'b10: begin
                    // An outward-facing endpoint turns around silently
                    if (!dir_q) begin
                        if (at_max) begin
                            count_d = cnt_dec;
                            dir_d   = 1'b1;
                        end else begin
                            count_d = cnt_inc;
                            if (cnt_inc == MAX) begin
                                dir_d = 1'b1;
                                tc_d  = 1'b1;
                            end
                        end
                    end else begin
                        if (at_zero) begin
                            count_d = cnt_inc;
                            dir_d   = 1'b0;
                        end else begin
                            count_d = cnt_dec;
                            if (cnt_dec == '0) begin
                                dir_d = 1'b0;
                                tc_d  = 1'b1;
                            end
                        end
                    end
                end
                2'b11: begin
                    dir_d = 1'b0;
                    if (!at_max) begin
                        count_d = cnt_inc;
                        tc_d    = (cnt_inc == MAX);
                    end
                end
            endcase
        end else if (en) begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            tick_q      <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            tick_q      <= tick_d;
            tc_q        <= tc_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tick  = tick_q;
    assign tc    = tc_q;
    assign leds  = count_q[CNT_W-1 -: LED_N] ^ {LED_N{LED_ACTIVE_LOW}};

endmodule
